mod_n_counter: RTL and testbench
================================

# mod_n_counter

Parametrised modulo-N synchronous counter, the general successor to our fixed mod-5 D-flip-flop counters. Counts up or down through 0..MODULUS-1, with clock enable, synchronous parallel load, and a runtime wrap/saturate mode. A combinational terminal-count output allows cascading, and registered status pulses flag wrap events and rejected loads. It sits wherever the design needs a programmable divider, a sequence index or a cascaded multi-digit counter.

## Interface
- MODULUS, 5, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2**WIDTH
- WIDTH, 4, bit width of the count and load value
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; no effect when low
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  mode: 0 = wrap at ends, 1 = saturate (hold) at ends
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- out  output  WIDTH  registered count
- tc  output  1  combinational terminal count, for cascading into the next stage's en
- wrapped  output  1  registered one-cycle pulse on a wrap event
- err  output  1  registered one-cycle pulse on a rejected load

## Operation
- Per-edge priority: rst > load > en > hold.
- rst: out = 0, wrapped = 0, err = 0.
- load with load_val < MODULUS: out = load_val. en and up are ignored that cycle, and wrapped = 0.
- load with load_val ≥ MODULUS: behaviour depends on configuration (see below).
- en=1, up=1:
  - out < MODULUS-1: out+1.
  - out = MODULUS-1: sat=0 gives 0 and wrapped pulses; sat=1 holds MODULUS-1 and wrapped stays 0.
- en=1, up=0:
  - out > 0: out-1.
  - out = 0: sat=0 gives MODULUS-1 and wrapped pulses; sat=1 holds 0.
- en=0, no load: out holds; wrapped = 0, err = 0.
- tc = en & ((up & out==MODULUS-1) | (~up & out==0)).
  - tc is independent of sat and of load.
  - Asserted in the cycle before the edge that would wrap or saturate.
- All arithmetic is WIDTH bits. Comparisons are against the constants MODULUS-1 and 0, so there is no 2**WIDTH overflow path.
- MODULUS = 2**WIDTH is legal and wraps naturally through the same compare logic.
- up and sat may change on any cycle; they are sampled at the edge.

## Timing
- out updates on the rising edge after its inputs are sampled. There is no latency beyond that single registration.
- wrapped and err are high for exactly the one cycle following the causing edge, aligned with the new out value.
- tc is purely combinational from out, en and up. It has zero latency and no registered copy.
- Reset mid-count or mid-load: out = 0 on that edge, and the pending load is discarded.
- Back-to-back loads: each load takes effect on its own edge.
- Consecutive wraps (MODULUS=2, en held high): wrapped pulses every second cycle in the up direction.

## Configuration
- Macro: MOD_N_COUNTER_LOAD_CHECK_EN.
- Defined: load_val ≥ MODULUS is rejected.
  - out holds its previous value.
  - err pulses for one cycle.
  - Counting is suppressed that cycle.
- Undefined: load_val ≥ MODULUS is clamped, so out = MODULUS-1.
  - err is tied to 0.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset, count up, wrap:
  - Stimulus: MODULUS=5, rst for 1 cycle, then en=1, up=1, sat=0 for 6 cycles.
  - Response: out = 0,1,2,3,4,0,1. tc high while out=4. wrapped high only while out=0 follows 4.
- Count down, wrap:
  - Stimulus: out=0, up=0, sat=0, en=1.
  - Response: out = 4,3,2. wrapped high in the out=4 cycle. tc high in the out=0 cycle.
- Saturate:
  - Stimulus: sat=1, count up from 3 for 4 cycles.
  - Response: out = 4,4,4,4. wrapped never asserts. tc stays high.
- Load priority:
  - Stimulus: load=1, load_val=2, with en=1, up=1 in the same cycle.
  - Response: out=2 next cycle, not 3. With rst=1 asserted simultaneously, out=0.
- Illegal load:
  - Stimulus: load_val=7 with MODULUS=5, from out=1.
  - Response with macro defined: out stays 1 and err pulses once.
  - Response with macro undefined: out=4 and err stays 0.
- Power-of-two wrap and cascade:
  - Stimulus 1: MODULUS=16, WIDTH=4, count up from 15.
  - Response 1: out=0 and wrapped pulses.
  - Stimulus 2: two instances chained via tc→en, lower stage MODULUS=10, upper stage MODULUS=6, counting 60 cycles.
  - Response 2: the pair returns to 0/0.

Source files
------------

// File: rtl/mod_n_counter.sv
// mod_n_counter: parametrised modulo-N up/down counter.
//   - counts through 0..MODULUS-1, wrap or saturate at the ends (runtime sat)
//   - synchronous parallel load, priority rst > load > en > hold
//   - combinational terminal count (tc) for cascading into the next stage's en
//   - registered one-cycle pulses: wrapped (wrap event), err (rejected load)
// Optional feature macro: MOD_N_COUNTER_LOAD_CHECK_EN
//   defined   : load_val >= MODULUS is rejected (out holds, err pulses)
//   undefined : load_val >= MODULUS is clamped to MODULUS-1, err tied low
// Legal parameters: 2 <= MODULUS <= 2**WIDTH.
module mod_n_counter #(
  parameter int MODULUS = 5,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped,
  output logic             err
);

  // Top count value. All arithmetic stays WIDTH bits wide; the ends are found
  // by comparing against constants, so MODULUS = 2**WIDTH needs no special case.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  // MODULUS widened by one bit so the load range check also covers 2**WIDTH,
  // in which case every load_val is legal.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic [WIDTH-1:0] next_out;
  logic             next_wrapped;
  logic             next_err;

  assign at_max  = (out == MAX_VAL);
  assign at_zero = (out == '0);
  assign load_ok = ({1'b0, load_val} < MOD_EXT);

  // Terminal count: the next enabled edge would wrap or saturate. It ignores
  // sat and load so a cascade sees a stable enable from the count alone.
  assign tc = en & ((up & at_max) | (~up & at_zero));

  // Next-state selection following the rst > load > en > hold priority
  // (rst is applied in the register block below).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else tree can leave a signal unassigned and infer a latch.
    next_out     = out;
    next_wrapped = 1'b0;
    next_err     = 1'b0;

    if (load) begin
      if (load_ok) begin
        next_out = load_val;
      end else begin
`ifdef MOD_N_COUNTER_LOAD_CHECK_EN
        // Rejected load: keep the count, suppress counting, flag the error.
        next_err = 1'b1;
`else
        // Out-of-range load clamps to the top of the range.
        next_out = MAX_VAL;
`endif
      end
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          next_out = out + 1'b1;
        end else if (!sat) begin
          next_out     = '0;
          next_wrapped = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          next_out = out - 1'b1;
        end else if (!sat) begin
          next_out     = MAX_VAL;
          next_wrapped = 1'b1;
        end
      end
    end
  end

  // Count and status registers with synchronous active-high reset; the status
  // pulses line up with the count value produced by the same edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      out     <= '0;
      wrapped <= 1'b0;
      err     <= 1'b0;
    end else begin
      out     <= next_out;
      wrapped <= next_wrapped;
      err     <= next_err;
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter: a MODULUS=5 main instance,
// a MODULUS=16 power-of-two instance and a 10x6 cascaded pair.
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Main instance, MODULUS=5
  logic       en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] out;
  logic       tc, wrapped, err;

  // Power-of-two instance, MODULUS=16
  logic       p_en = 1'b0, p_up = 1'b1, p_load = 1'b0;
  logic [3:0] p_load_val = '0;
  logic [3:0] p_out;
  logic       p_tc, p_wrapped, p_err;

  // Cascade: low digit MODULUS=10 feeds its tc into high digit MODULUS=6
  logic       c_en = 1'b0;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, hi_tc, lo_wrapped, hi_wrapped, lo_err, hi_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.MODULUS(5), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .out(out), .tc(tc), .wrapped(wrapped), .err(err)
  );

  mod_n_counter #(.MODULUS(16), .WIDTH(4)) dut_pow2 (
    .clk(clk), .rst(rst), .en(p_en), .up(p_up), .sat(1'b0), .load(p_load),
    .load_val(p_load_val), .out(p_out), .tc(p_tc), .wrapped(p_wrapped), .err(p_err)
  );

  mod_n_counter #(.MODULUS(10), .WIDTH(4)) dut_lo (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(4'd0), .out(lo_out), .tc(lo_tc), .wrapped(lo_wrapped), .err(lo_err)
  );

  mod_n_counter #(.MODULUS(6), .WIDTH(4)) dut_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(4'd0), .out(hi_out), .tc(hi_tc), .wrapped(hi_wrapped), .err(hi_err)
  );

  // Advance one edge; outputs are then sampled 1 time unit after it and new
  // inputs are applied at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0;
    tick();
    rst = 1'b0; en = 1'b0;
    #1;
    total_cnt++;
    if (out !== 4'd0) $display("FAIL reset_out: got %0d expected 0", out);
    else pass_cnt++;
    total_cnt++;
    if (wrapped !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_flags: got wrapped=%b err=%b expected 0/0", wrapped, err);
    else pass_cnt++;
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL reset_tc_en_low: got %b expected 0", tc);
    else pass_cnt++;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_out [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
    logic       exp_wr  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] prev = 4'd0;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total_cnt++;
      if (tc !== (prev == 4'd4))
        $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, prev == 4'd4);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out !== exp_out[i] || wrapped !== exp_wr[i])
        $display("FAIL up_step[%0d]: got out=%0d wrapped=%b expected out=%0d wrapped=%b",
                 i, out, wrapped, exp_out[i], exp_wr[i]);
      else pass_cnt++;
      prev = exp_out[i];
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_out [3] = '{4'd4, 4'd3, 4'd2};
    logic       exp_wr  [3] = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    #1;
    total_cnt++;
    if (tc !== 1'b1) $display("FAIL down_tc_at_zero: got %b expected 1", tc);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (out !== exp_out[i] || wrapped !== exp_wr[i])
        $display("FAIL down_step[%0d]: got out=%0d wrapped=%b expected out=%0d wrapped=%b",
                 i, out, wrapped, exp_out[i], exp_wr[i]);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (out !== 4'd4 || wrapped !== 1'b0 || tc !== 1'b1)
        $display("FAIL sat_up[%0d]: got out=%0d wrapped=%b tc=%b expected out=4 wrapped=0 tc=1",
                 i, out, wrapped, tc);
      else pass_cnt++;
    end
    // Saturate low end: count down from 1 holds at 0.
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (out !== 4'd0 || wrapped !== 1'b0)
      $display("FAIL sat_down: got out=%0d wrapped=%b expected out=0 wrapped=0", out, wrapped);
    else pass_cnt++;
    en = 1'b0; sat = 1'b0; up = 1'b1;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 4'd4;
    tick();
    // out=4, counting up would wrap, but the load wins and tc ignores load.
    en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b1; load_val = 4'd2;
    #1;
    total_cnt++;
    if (tc !== 1'b1) $display("FAIL load_tc_indep: got %b expected 1", tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out !== 4'd2 || wrapped !== 1'b0)
      $display("FAIL load_over_en: got out=%0d wrapped=%b expected out=2 wrapped=0", out, wrapped);
    else pass_cnt++;
    // Reset beats a simultaneous load.
    rst = 1'b1; load_val = 4'd3;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (out !== 4'd0) $display("FAIL rst_over_load: got %0d expected 0", out);
    else pass_cnt++;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [3] = '{4'd1, 4'd3, 4'd0};
    en = 1'b1; up = 1'b0; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_val = vals[i];
      tick();
      total_cnt++;
      if (out !== vals[i]) $display("FAIL b2b_load[%0d]: got %0d expected %0d", i, out, vals[i]);
      else pass_cnt++;
    end
    load = 1'b0; en = 1'b0;
    tick();
    total_cnt++;
    if (out !== 4'd0 || wrapped !== 1'b0)
      $display("FAIL hold_en_low: got out=%0d wrapped=%b expected out=0 wrapped=0", out, wrapped);
    else pass_cnt++;
    up = 1'b1;
  endtask

  task automatic test_illegal_load();
`ifdef MOD_N_COUNTER_LOAD_CHECK_EN
    logic [3:0] exp_out = 4'd1;
    logic       exp_err = 1'b1;
`else
    logic [3:0] exp_out = 4'd4;
    logic       exp_err = 1'b0;
`endif
    load = 1'b1; load_val = 4'd1;
    tick();
    en = 1'b1; up = 1'b1; load_val = 4'd7;
    tick();
    total_cnt++;
    if (out !== exp_out || err !== exp_err)
      $display("FAIL illegal_load: got out=%0d err=%b expected out=%0d err=%b",
               out, err, exp_out, exp_err);
    else pass_cnt++;
    load = 1'b0; en = 1'b0;
    tick();
    total_cnt++;
    if (out !== exp_out || err !== 1'b0)
      $display("FAIL illegal_load_after: got out=%0d err=%b expected out=%0d err=0",
               out, err, exp_out);
    else pass_cnt++;
  endtask

  task automatic test_pow2();
    p_load = 1'b1; p_load_val = 4'd15;
    tick();
    p_load = 1'b0; p_en = 1'b1; p_up = 1'b1;
    #1;
    total_cnt++;
    if (p_out !== 4'd15 || p_err !== 1'b0 || p_tc !== 1'b1)
      $display("FAIL pow2_load15: got out=%0d err=%b tc=%b expected out=15 err=0 tc=1",
               p_out, p_err, p_tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (p_out !== 4'd0 || p_wrapped !== 1'b1)
      $display("FAIL pow2_wrap_up: got out=%0d wrapped=%b expected out=0 wrapped=1", p_out, p_wrapped);
    else pass_cnt++;
    p_up = 1'b0;
    tick();
    total_cnt++;
    if (p_out !== 4'd15 || p_wrapped !== 1'b1)
      $display("FAIL pow2_wrap_down: got out=%0d wrapped=%b expected out=15 wrapped=1", p_out, p_wrapped);
    else pass_cnt++;
    p_en = 1'b0;
  endtask

  task automatic test_cascade();
    rst = 1'b1;
    tick();
    rst = 1'b0; c_en = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    total_cnt++;
    if (lo_out !== 4'd7 || hi_out !== 4'd3)
      $display("FAIL cascade_37: got hi/lo=%0d/%0d expected 3/7", hi_out, lo_out);
    else pass_cnt++;
    for (int i = 37; i < 59; i++) tick();
    total_cnt++;
    if (lo_out !== 4'd9 || hi_out !== 4'd5 || lo_tc !== 1'b1 || hi_tc !== 1'b1)
      $display("FAIL cascade_59: got hi/lo=%0d/%0d tc=%b/%b expected 5/9 tc=1/1",
               hi_out, lo_out, hi_tc, lo_tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (lo_out !== 4'd0 || hi_out !== 4'd0 || hi_wrapped !== 1'b1)
      $display("FAIL cascade_60: got hi/lo=%0d/%0d hi_wrapped=%b expected 0/0 hi_wrapped=1",
               hi_out, lo_out, hi_wrapped);
    else pass_cnt++;
    c_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_priority();
    test_back_to_back();
    test_illegal_load();
    test_pow2();
    test_cascade();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
